// File: rtl/dm_arb_pkg.sv
// Shared constants and types for the data-memory arbiter.
package dm_arb_pkg;

    localparam int unsigned DEF_ADDR_W       = 32;
    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_STARVE_LIMIT = 4;

    // Access sequencer state encoding (kept as plain constants for legacy compatibility)
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t RESP  = 2'd2;

    // Grant encoding
    typedef logic gnt_t;
    localparam gnt_t GNT_CPU = 1'b0;
    localparam gnt_t GNT_DBG = 1'b1;

endpackage

// File: rtl/dm_arb_sel.sv
// Combinational grant select: CPU has priority unless debug has been starved.
module dm_arb_sel
    import dm_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic starve_full,
    output logic any_req,
    output gnt_t gnt
);

    // Debug wins when it is the only requester or when its wait limit is reached
    always_comb begin
        any_req = cpu_req | dbg_req;
        gnt     = GNT_CPU;
        if (dbg_req && (!cpu_req || starve_full)) begin
            gnt = GNT_DBG;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the CPU MEM stage and the debug/dump port onto one
// single-port synchronous data memory: IDLE -> ISSUE -> RESP per access.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_t            state;
    gnt_t              gnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic [CNT_W-1:0]  starve_cnt;

    logic any_req;
    gnt_t gnt;
    logic starve_full;
    logic resp_data_sel;

    assign starve_full = (starve_cnt == CNT_MAX);

    dm_arb_sel u_sel (
        .cpu_req     (cpu_req_i),
        .dbg_req     (dbg_req_i),
        .starve_full (starve_full),
        .any_req     (any_req),
        .gnt         (gnt)
    );

    // Sequencer, winner capture, starvation counter and held read data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            gnt_q       <= GNT_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            starve_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= ISSUE;
                        gnt_q <= gnt;
                        if (gnt == GNT_DBG) begin
                            we_q    <= dbg_we_i;
                            addr_q  <= dbg_addr_i;
                            wdata_q <= dbg_wdata_i;
                        end else begin
                            we_q    <= cpu_we_i;
                            addr_q  <= cpu_addr_i;
                            wdata_q <= cpu_wdata_i;
                        end
                    end
                    if (dbg_req_i && gnt == GNT_CPU) begin
                        if (!starve_full) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                ISSUE: state <= RESP;
                RESP: begin
                    state <= IDLE;
                    if (gnt_q == GNT_DBG) begin
                        dbg_rdata_q <= we_q ? '0 : mem_rdata_i;
                    end else begin
                        cpu_rdata_q <= we_q ? '0 : mem_rdata_i;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state and captured registers only
    always_comb begin
        mem_en_o    = (state == ISSUE);
        mem_we_o    = (state == ISSUE) && we_q;
        mem_addr_o  = (state == IDLE) ? '0 : addr_q;
        mem_wdata_o = (state == IDLE) ? '0 : wdata_q;

        cpu_ack_o   = (state == RESP) && (gnt_q == GNT_CPU);
        dbg_ack_o   = (state == RESP) && (gnt_q == GNT_DBG);
        cpu_stall_o = cpu_req_i && !cpu_ack_o;

        // The memory register loaded at ISSUE->RESP presents data during RESP;
        // the ack cycle forwards it, and the port register keeps it afterwards.
        resp_data_sel = (state == RESP) && !we_q;
        cpu_rdata_o   = cpu_rdata_q;
        dbg_rdata_o   = dbg_rdata_q;
        if (cpu_ack_o) begin
            cpu_rdata_o = resp_data_sel ? mem_rdata_i : '0;
        end
        if (dbg_ack_o) begin
            dbg_rdata_o = resp_data_sel ? mem_rdata_i : '0;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a synchronous memory model.
module tb_dm_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cpu_req_i, cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i;
    logic [31:0] cpu_rdata_o;
    logic        cpu_ack_o, cpu_stall_o;
    logic        dbg_req_i, dbg_we_i;
    logic [31:0] dbg_addr_i, dbg_wdata_i;
    logic [31:0] dbg_rdata_o;
    logic        dbg_ack_o;
    logic        mem_en_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:15];

    dm_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_ack_o   (cpu_ack_o),
        .cpu_stall_o (cpu_stall_o),
        .dbg_req_i   (dbg_req_i),
        .dbg_we_i    (dbg_we_i),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_wdata_i (dbg_wdata_i),
        .dbg_rdata_o (dbg_rdata_o),
        .dbg_ack_o   (dbg_ack_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic int midx(input logic [31:0] a);
        return int'(a % 32'd16);
    endfunction

    // Synchronous single-port memory: read data valid the cycle after mem_en_o
    always @(posedge clk_i) begin
        if (mem_en_o) begin
            if (mem_we_o) mem[midx(mem_addr_o)] <= mem_wdata_o;
            else          mem_rdata_i <= mem[midx(mem_addr_o)];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One complete access from IDLE; returns with FSM back in IDLE
    task automatic access(input bit is_dbg, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic [31:0] exp_other_rd, input string tag);
        if (is_dbg) begin
            dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wdata;
        end else begin
            cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata;
        end
        #1;
        check({tag, " stall_req"}, 64'(cpu_stall_o), 64'(!is_dbg));
        tick();
        check({tag, " issue_en"},    64'(mem_en_o),    64'd1);
        check({tag, " issue_we"},    64'(mem_we_o),    64'(we));
        check({tag, " issue_addr"},  64'(mem_addr_o),  64'(addr));
        check({tag, " issue_wdata"}, 64'(mem_wdata_o), 64'(wdata));
        check({tag, " issue_noack"}, 64'({cpu_ack_o, dbg_ack_o}), 64'd0);
        check({tag, " issue_stall"}, 64'(cpu_stall_o), 64'(!is_dbg));
        tick();
        check({tag, " resp_ack"},   64'({cpu_ack_o, dbg_ack_o}), is_dbg ? 64'd1 : 64'd2);
        check({tag, " resp_en"},    64'({mem_en_o, mem_we_o}), 64'd0);
        check({tag, " resp_stall"}, 64'(cpu_stall_o), 64'd0);
        if (is_dbg) begin
            check({tag, " rdata"},      64'(dbg_rdata_o), 64'(exp_rd));
            check({tag, " other_hold"}, 64'(cpu_rdata_o), 64'(exp_other_rd));
            dbg_req_i = 1'b0;
        end else begin
            check({tag, " rdata"},      64'(cpu_rdata_o), 64'(exp_rd));
            check({tag, " other_hold"}, 64'(dbg_rdata_o), 64'(exp_other_rd));
            cpu_req_i = 1'b0;
        end
        tick();
        check({tag, " idle_addr"}, 64'(mem_addr_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[1] = 32'h11;
        mem[2] = 32'h22;
        mem[5] = 32'h7;
        mem_rdata_i = 32'h0;

        rst_i = 1'b1;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;

        // Reset state
        #2;
        check("rst outputs", 64'({cpu_ack_o, dbg_ack_o, mem_en_o, mem_we_o, cpu_stall_o}), 64'd0);
        check("rst mem_addr", 64'(mem_addr_o), 64'd0);
        check("rst rdata", 64'({cpu_rdata_o, dbg_rdata_o}), 64'd0);
        cpu_req_i = 1'b1;
        #1;
        check("rst stall follows req", 64'(cpu_stall_o), 64'd1);
        tick();
        check("rst held across clk", 64'({cpu_ack_o, mem_en_o}), 64'd0);
        cpu_req_i = 1'b0;
        rst_i = 1'b0;
        tick();

        // CPU read, CPU write, debug readback
        access(1'b0, 1'b0, 32'd5, 32'h0,  32'h7,  32'h0, "cpu_rd5");
        access(1'b0, 1'b1, 32'd3, 32'h55, 32'h0,  32'h0, "cpu_wr3");
        access(1'b1, 1'b0, 32'd3, 32'h0,  32'h55, 32'h0, "dbg_rd3");

        // Back-to-back CPU reads with req held through ack
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'd1;
        tick();
        tick();
        check("b2b ack1",   64'(cpu_ack_o),   64'd1);
        check("b2b data1",  64'(cpu_rdata_o), 64'h11);
        cpu_addr_i = 32'd2;
        tick();
        check("b2b gap_ack",   64'({cpu_ack_o, mem_en_o}), 64'd0);
        check("b2b gap_stall", 64'(cpu_stall_o), 64'd1);
        check("b2b gap_hold",  64'(cpu_rdata_o), 64'h11);
        tick();
        check("b2b issue2", 64'({mem_en_o, 1'b0, mem_addr_o}), {31'd0, 1'b1, 1'b0, 32'd2});
        tick();
        check("b2b ack2",  64'(cpu_ack_o),   64'd1);
        check("b2b data2", 64'(cpu_rdata_o), 64'h22);
        cpu_req_i = 1'b0;
        tick();

        // Both requesting continuously: CPU x4 then DBG, repeating
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'd1;
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'd2;
        for (int i = 0; i < 10; i++) begin
            tick();
            tick();
            if (i % 5 == 4) begin
                check($sformatf("starve grant %0d", i), 64'({cpu_ack_o, dbg_ack_o}), 64'd1);
                check($sformatf("starve data %0d", i),  64'(dbg_rdata_o), 64'h22);
            end else begin
                check($sformatf("starve grant %0d", i), 64'({cpu_ack_o, dbg_ack_o}), 64'd2);
                check($sformatf("starve data %0d", i),  64'(cpu_rdata_o), 64'h11);
            end
            tick();
        end
        cpu_req_i = 1'b0;
        dbg_req_i = 1'b0;
        tick();

        // Reset during ISSUE of a write aborts it
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'd9; cpu_wdata_i = 32'hAA;
        tick();
        check("abort pre_we", 64'(mem_we_o), 64'd1);
        rst_i = 1'b1;
        #1;
        check("abort we_drop", 64'({mem_en_o, mem_we_o}), 64'd0);
        check("abort addr0",   64'(mem_addr_o), 64'd0);
        check("abort wdata0",  64'(mem_wdata_o), 64'd0);
        check("abort stall",   64'(cpu_stall_o), 64'd1);
        tick();
        check("abort noack", 64'({cpu_ack_o, dbg_ack_o}), 64'd0);
        cpu_req_i = 1'b0;
        rst_i = 1'b0;
        tick();
        check("post_rst outputs", 64'({cpu_ack_o, dbg_ack_o, mem_en_o, mem_we_o, cpu_stall_o}), 64'd0);
        check("post_rst rdata",   64'({cpu_rdata_o, dbg_rdata_o}), 64'd0);
        tick();
        access(1'b1, 1'b0, 32'd9, 32'h0, 32'h0, 32'h0, "dbg_rd9");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, word address width passed to data memory.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter STARVE_LIMIT, default 4, CPU wins allowed while debug waits before debug is forced first.
REQ-004 Ports: clk_i  in  1  single clock, all state updates on its rising edge.
REQ-005 Ports: rst_i  in  1  asynchronous, active-high reset.
REQ-006 Ports: cpu_req_i/cpu_we_i  in  1/1  CPU MEM-stage access request / write enable.
REQ-007 Ports: cpu_addr_i/cpu_wdata_i  in  ADDR_W/DATA_W  CPU address / write data.
REQ-008 Ports: cpu_rdata_o/cpu_ack_o/cpu_stall_o  out  DATA_W/1/1  read data / done pulse / pipeline freeze.
REQ-009 Ports: dbg_req_i/dbg_we_i/dbg_addr_i/dbg_wdata_i  in  1/1/ADDR_W/DATA_W  debug/dump port request.
REQ-010 Ports: dbg_rdata_o/dbg_ack_o  out  DATA_W/1  debug read data / done pulse.
REQ-011 Ports: mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o  out  1/1/ADDR_W/DATA_W  single-port data memory drive.
REQ-012 Ports: mem_rdata_i  in  DATA_W  memory read data, valid one cycle after mem_en_o.

Function
REQ-013 FSM states IDLE, ISSUE, RESP; IDLE->ISSUE on any sampled request, ISSUE->RESP always, RESP->IDLE always.
REQ-014 In IDLE, arbitration: only one requester -> it wins; both -> CPU wins unless starve_cnt == STARVE_LIMIT, then debug wins.
REQ-015 Winner's we/addr/wdata captured into registers at the IDLE->ISSUE edge; mem_* outputs driven only from these registers.
REQ-016 mem_en_o = 1 only in ISSUE; mem_we_o = 1 only in ISSUE for a write; mem_addr_o/mem_wdata_o hold captured values, 0 in IDLE.
REQ-017 In RESP, winner's ack_o = 1 for exactly one cycle; its rdata_o = mem_rdata_i registered at ISSUE->RESP edge (reads), 0 for writes.
REQ-018 Latency: request sampled at edge N -> mem_en_o high cycle N+1 -> ack high cycle N+2; throughput one access per 3 cycles.
REQ-019 Requester holds req/we/addr/wdata stable until ack; req still high in the cycle after ack is a new access.
REQ-020 cpu_stall_o = cpu_req_i AND NOT cpu_ack_o (combinational), so pipeline freezes until its access completes.
REQ-021 starve_cnt (saturating at STARVE_LIMIT) increments when CPU is granted while dbg_req_i = 1; clears when debug is granted or dbg_req_i = 0 in IDLE.
REQ-022 Requests arriving in ISSUE/RESP are not sampled; they wait for the next IDLE.
REQ-023 rdata_o of the non-winning port holds its previous value; ack_o never asserted on both ports in one cycle.

Reset
REQ-024 rst_i asserted: state IDLE, starve_cnt 0, all captured registers 0, all outputs 0 (cpu_stall_o follows cpu_req_i), immediately, without a clock.
REQ-025 Reset during ISSUE aborts the access: mem_en_o/mem_we_o drop asynchronously, no ack issued; requester re-requests after release.
REQ-026 First arbitration occurs on the first rising clk_i edge after rst_i deasserts.

Structure
REQ-027 Shared package dm_arb_pkg holds the state enum (IDLE, ISSUE, RESP), grant encoding (GNT_CPU, GNT_DBG) and default parameter constants.
REQ-028 One sub-module, dm_arb_sel: combinational grant select from cpu_req, dbg_req, starve_cnt == STARVE_LIMIT.

Verification
REQ-029 CPU read only, addr 5, memory[5]=7 -> mem_en_o cycle N+1, cpu_ack_o with cpu_rdata_o=7 cycle N+2, cpu_stall_o high N..N+1.
REQ-030 CPU write addr 3 data 0x55 -> mem_we_o one cycle, mem_addr_o=3, mem_wdata_o=0x55; readback by debug returns 0x55.
REQ-031 Both requesting continuously, STARVE_LIMIT=4 -> grant order CPU,CPU,CPU,CPU,DBG, repeating; no double ack.
REQ-032 Debug held off only while CPU idle -> debug granted immediately, starve_cnt stays 0.
REQ-033 rst_i pulsed during ISSUE of a write -> mem_we_o low within same cycle, no ack, state IDLE, all outputs 0 after release.
REQ-034 CPU holds req after ack for back-to-back reads addr 1,2 -> acks at cycles N+2 and N+5, data matches memory.
